// File: rtl/mem_stage_pkg.sv
// Shared widths, load-op encodings and bus layouts for the MEM pipeline stage.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 74;
    localparam int MS_TO_WS_BUS_WD = 70;
    localparam int MS_TO_DS_FWD_WD = 38;

    typedef enum logic [2:0] {
        LD_W  = 3'd0,
        LD_B  = 3'd1,
        LD_H  = 3'd2,
        LD_BU = 3'd3,
        LD_HU = 3'd4
    } ld_op_e;

    typedef struct packed {
        logic [2:0]  ld_op;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_to_ms_t;

    typedef struct packed {
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ms_to_ws_t;

    typedef struct packed {
        logic        fwd_we;
        logic [4:0]  fwd_dest;
        logic [31:0] fwd_data;
    } ms_fwd_t;

endpackage

// File: rtl/mem_stage_if.sv
// Signal bundle around the MEM stage: EX handshake, WB handshake, SRAM read data, ID forwarding.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic                       es_to_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
    logic                       ms_allowin;
    logic                       ms_to_ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
    logic                       ws_allowin;
    logic [31:0]                data_sram_rdata;
    logic [MS_TO_DS_FWD_WD-1:0] ms_to_ds_fwd_bus;

    // Surrounding pipeline / environment view.
    modport master (
        output es_to_ms_valid, es_to_ms_bus, ws_allowin, data_sram_rdata,
        input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_fwd_bus
    );

    // MEM stage view.
    modport slave (
        input  es_to_ms_valid, es_to_ms_bus, ws_allowin, data_sram_rdata,
        output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_fwd_bus
    );

endinterface

// File: rtl/mem_stage_load_align.sv
// Combinational load extraction: selects the byte/halfword at the low address bits and extends it.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] mem_word,
    input  logic [1:0]  addr,
    input  logic [2:0]  ld_op,
    output logic [31:0] load_data
);

    logic [31:0] word_shift;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign word_shift = mem_word >> {addr, 3'b000};
    assign byte_sel   = word_shift[7:0];
    assign half_sel   = addr[1] ? mem_word[31:16] : mem_word[15:0];

    always_comb begin
        // NOTE: default assigned first so every path drives load_data -- no latch inferred.
        load_data = mem_word;
        case (ld_op)
            LD_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   load_data = {24'd0, byte_sel};
            LD_H:    load_data = {{16{half_sel[15]}}, half_sel};
            LD_HU:   load_data = {16'd0, half_sel};
            default: load_data = mem_word;  // LD_W and unused encodings 5..7
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: valid/allowin pipeline register, SRAM load-data capture across stalls,
// load alignment, WB bus and ID forwarding bus.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    mem_stage_if.slave pipe
);

    es_to_ms_t   es_in;
    es_to_ms_t   ms_r;
    ms_to_ws_t   ws_out;
    ms_fwd_t     fwd;

    logic        ms_valid;
    logic        first_cycle;
    logic        ms_ready_go;
    logic        ms_allowin;
    logic        accept;
    logic [31:0] rdata_buf;
    logic [31:0] mem_word;
    logic [31:0] load_data;
    logic [31:0] final_result;

    assign es_in       = pipe.es_to_ms_bus;
    assign ms_ready_go = 1'b1;
    assign ms_allowin  = !ms_valid || (ms_ready_go && pipe.ws_allowin);
    assign accept      = pipe.es_to_ms_valid && ms_allowin;

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid    <= 1'b0;
            first_cycle <= 1'b0;
        end else begin
            if (ms_allowin) begin
                ms_valid <= pipe.es_to_ms_valid;
            end
            first_cycle <= accept;
        end
    end

    // NOTE: payload registers are deliberately not reset; ms_valid qualifies them.
    always_ff @(posedge clk) begin
        if (accept) begin
            ms_r <= es_in;
        end
        if (first_cycle) begin
            rdata_buf <= pipe.data_sram_rdata;
        end
    end

    // SRAM data is only live the cycle after capture; later stall cycles read the buffered copy.
    assign mem_word = first_cycle ? pipe.data_sram_rdata : rdata_buf;

    load_align u_load_align (
        .mem_word  (mem_word),
        .addr      (ms_r.alu_result[1:0]),
        .ld_op     (ms_r.ld_op),
        .load_data (load_data)
    );

    assign final_result = ms_r.res_from_mem ? load_data : ms_r.alu_result;

    assign ws_out.gr_we        = ms_r.gr_we;
    assign ws_out.dest         = ms_r.dest;
    assign ws_out.final_result = final_result;
    assign ws_out.pc           = ms_r.pc;

    assign fwd.fwd_we   = ms_valid && ms_r.gr_we && (ms_r.dest != 5'd0);
    assign fwd.fwd_dest = ms_r.dest;
    assign fwd.fwd_data = final_result;

    assign pipe.ms_allowin       = ms_allowin;
    assign pipe.ms_to_ws_valid   = ms_valid && ms_ready_go;
    assign pipe.ms_to_ws_bus     = ws_out;
    assign pipe.ms_to_ds_fwd_bus = fwd;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed load/stall/forward/reset cases plus a
// randomized run against a transaction-level model of the stage.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;

    mem_stage_if bus ();

    mem_stage u_dut (
        .clk   (clk),
        .reset (reset),
        .pipe  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no summary want summary");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic [73:0] mk_inst(input int op, input bit rfm, input bit we,
                                            input int dest, input logic [31:0] alu,
                                            input logic [31:0] pc);
        logic [73:0] b;
        b = {op[2:0], rfm, we, dest[4:0], alu, pc};
        return b;
    endfunction

    function automatic logic [31:0] model_result(input logic [73:0] b, input logic [31:0] word);
        int unsigned op;
        int unsigned a;
        logic [31:0] v;
        op = 32'(b[73:71]);
        a  = 32'(b[33:32]);
        if (b[70] == 1'b0) return b[63:32];
        case (op)
            1, 3: begin
                v = (word >> (8 * a)) % 256;
                if (op == 1 && v >= 128) v = v - 256;
            end
            2, 4: begin
                v = (word >> (16 * (a / 2))) % 65536;
                if (op == 2 && v >= 32768) v = v - 65536;
            end
            default: v = word;
        endcase
        return v;
    endfunction

    function automatic logic [69:0] model_ws(input logic [73:0] b, input logic [31:0] word);
        return {b[69], b[68:64], model_result(b, word), b[31:0]};
    endfunction

    function automatic logic [37:0] model_fwd(input bit valid, input logic [73:0] b,
                                              input logic [31:0] word);
        bit we;
        we = valid && b[69] && (b[68:64] != 5'd0);
        return {we, b[68:64], model_result(b, word)};
    endfunction

    function automatic logic [73:0] rand_inst(input logic [31:0] pc);
        int dest;
        dest = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 31));
        return mk_inst(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), dest, $urandom, pc);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for a single edge, then play the SRAM word in the capture cycle.
    task automatic issue(input logic [73:0] b, input logic [31:0] word);
        bus.es_to_ms_valid = 1'b1;
        bus.es_to_ms_bus   = b;
        tick();
        bus.es_to_ms_valid  = 1'b0;
        bus.data_sram_rdata = word;
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset               = 1'b1;
        bus.es_to_ms_valid  = 1'b1;
        bus.es_to_ms_bus    = mk_inst(0, 1'b0, 1'b1, 3, 32'h1, 32'h0);
        bus.ws_allowin      = 1'b0;
        bus.data_sram_rdata = 32'h0;
        tick();
        tick();
        n_checks++;
        if (bus.ms_to_ws_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.ms_to_ws_valid);
        else n_pass++;
        n_checks++;
        if (bus.ms_allowin !== 1'b1) $display("FAIL reset_allowin: got %b want 1", bus.ms_allowin);
        else n_pass++;
        n_checks++;
        if (bus.ms_to_ds_fwd_bus[37] !== 1'b0) $display("FAIL reset_fwd_we: got %b want 0", bus.ms_to_ds_fwd_bus[37]);
        else n_pass++;
        reset              = 1'b0;
        bus.es_to_ms_valid = 1'b0;
        bus.ws_allowin     = 1'b1;
        tick();
    endtask

    task automatic test_load_vectors();
        int          ops[6]   = '{1, 4, 2, 3, 0, 3};
        logic [31:0] alus[6]  = '{32'h1003, 32'h2002, 32'h2002, 32'h0006, 32'h0004, 32'h0001};
        logic [31:0] words[6] = '{32'h80FF_1234, 32'hBEEF_0001, 32'hBEEF_0001,
                                  32'h80FF_1234, 32'h80FF_1234, 32'h80FF_1234};
        logic [31:0] exps[6]  = '{32'hFFFF_FF80, 32'h0000_BEEF, 32'hFFFF_BEEF,
                                  32'h0000_00FF, 32'h80FF_1234, 32'h0000_0012};
        logic [73:0] b;
        bus.ws_allowin = 1'b1;
        for (int i = 0; i < 6; i++) begin
            b = mk_inst(ops[i], 1'b1, 1'b1, 7, alus[i], 32'h100 + 32'(4 * i));
            issue(b, words[i]);
            n_checks++;
            if (bus.ms_to_ws_valid !== 1'b1) $display("FAIL ldvec_valid[%0d]: got %b want 1", i, bus.ms_to_ws_valid);
            else n_pass++;
            n_checks++;
            if (bus.ms_to_ws_bus[63:32] !== exps[i])
                $display("FAIL ldvec_result[%0d]: got %h want %h", i, bus.ms_to_ws_bus[63:32], exps[i]);
            else n_pass++;
            n_checks++;
            if (bus.ms_to_ws_bus[31:0] !== b[31:0])
                $display("FAIL ldvec_pc[%0d]: got %h want %h", i, bus.ms_to_ws_bus[31:0], b[31:0]);
            else n_pass++;
        end
        tick();
    endtask

    task automatic test_stall_hold();
        int pulses = 0;
        bus.ws_allowin = 1'b1;
        issue(mk_inst(0, 1'b1, 1'b1, 9, 32'h2000, 32'h300), 32'h1234_5678);
        bus.ws_allowin = 1'b0;
        #1;
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (bus.ms_allowin !== 1'b0) $display("FAIL stall_allowin[%0d]: got %b want 0", c, bus.ms_allowin);
            else n_pass++;
            n_checks++;
            if (bus.ms_to_ws_bus[63:32] !== 32'h1234_5678)
                $display("FAIL stall_result[%0d]: got %h want 12345678", c, bus.ms_to_ws_bus[63:32]);
            else n_pass++;
            if (c < 3) begin
                tick();
                bus.data_sram_rdata = 32'hDEAD_DEAD;
                #1;
            end
        end
        bus.ws_allowin = 1'b1;
        #1;
        for (int c = 0; c < 4; c++) begin
            if (bus.ms_to_ws_valid && bus.ws_allowin) pulses++;
            tick();
        end
        n_checks++;
        if (pulses != 1) $display("FAIL stall_release_pulses: got %0d want 1", pulses);
        else n_pass++;
    endtask

    task automatic test_forward();
        bus.ws_allowin = 1'b1;
        issue(mk_inst(0, 1'b0, 1'b1, 5, 32'hCAFE_0000, 32'h400), 32'h5555_AAAA);
        n_checks++;
        if (bus.ms_to_ds_fwd_bus !== {1'b1, 5'd5, 32'hCAFE_0000})
            $display("FAIL fwd_dest5: got %h want %h", bus.ms_to_ds_fwd_bus, {1'b1, 5'd5, 32'hCAFE_0000});
        else n_pass++;
        n_checks++;
        if (bus.ms_to_ws_bus !== {1'b1, 5'd5, 32'hCAFE_0000, 32'h400})
            $display("FAIL fwd_ws_bus: got %h want %h", bus.ms_to_ws_bus, {1'b1, 5'd5, 32'hCAFE_0000, 32'h400});
        else n_pass++;
        issue(mk_inst(0, 1'b0, 1'b1, 0, 32'hCAFE_0000, 32'h404), 32'h5555_AAAA);
        n_checks++;
        if (bus.ms_to_ds_fwd_bus[37] !== 1'b0) $display("FAIL fwd_dest0_we: got %b want 0", bus.ms_to_ds_fwd_bus[37]);
        else n_pass++;
        issue(mk_inst(0, 1'b0, 1'b1, 12, 32'h0BAD_F00D, 32'h408), 32'h5555_AAAA);
        tick();
        n_checks++;
        if (bus.ms_to_ws_valid !== 1'b0) $display("FAIL drain_empty_valid: got %b want 0", bus.ms_to_ws_valid);
        else n_pass++;
        n_checks++;
        if (bus.ms_to_ds_fwd_bus[37] !== 1'b0) $display("FAIL drain_empty_fwd_we: got %b want 0", bus.ms_to_ds_fwd_bus[37]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [73:0] insts[16];
        logic [31:0] words[16];
        for (int i = 0; i < 16; i++) begin
            insts[i] = rand_inst(32'h4000 + 32'(4 * i));
            words[i] = $urandom;
        end
        bus.ws_allowin     = 1'b1;
        bus.es_to_ms_valid = 1'b1;
        bus.es_to_ms_bus   = insts[0];
        for (int i = 0; i < 16; i++) begin
            tick();
            bus.data_sram_rdata = words[i];
            if (i < 15) bus.es_to_ms_bus = insts[i + 1];
            else bus.es_to_ms_valid = 1'b0;
            #1;
            n_checks++;
            if (bus.ms_to_ws_valid !== 1'b1) $display("FAIL b2b_valid[%0d]: got %b want 1", i, bus.ms_to_ws_valid);
            else n_pass++;
            n_checks++;
            if (bus.ms_to_ws_bus !== model_ws(insts[i], words[i]))
                $display("FAIL b2b_bus[%0d]: got %h want %h", i, bus.ms_to_ws_bus, model_ws(insts[i], words[i]));
            else n_pass++;
        end
        tick();
        n_checks++;
        if (bus.ms_to_ws_valid !== 1'b0) $display("FAIL b2b_tail_valid: got %b want 0", bus.ms_to_ws_valid);
        else n_pass++;
    endtask

    task automatic test_random();
        bit          m_valid = 1'b0;
        logic [73:0] m_bus   = '0;
        logic [31:0] m_word  = '0;
        bit          es_v, ws_a;
        logic [73:0] es_b;
        logic [31:0] pc = 32'h8000;
        es_v = 1'b0;
        ws_a = 1'b1;
        es_b = rand_inst(pc);
        bus.es_to_ms_valid = es_v;
        bus.es_to_ms_bus   = es_b;
        bus.ws_allowin     = ws_a;
        for (int c = 0; c < 300; c++) begin
            tick();
            bus.data_sram_rdata = $urandom;
            if (!m_valid || ws_a) begin
                m_valid = es_v;
                if (es_v) begin
                    m_bus  = es_b;
                    m_word = $urandom;
                    bus.data_sram_rdata = m_word;
                    pc = pc + 32'd4;
                end
            end
            es_v = ($urandom_range(0, 9) < 7);
            ws_a = ($urandom_range(0, 9) < 6);
            es_b = rand_inst(pc);
            bus.es_to_ms_valid = es_v;
            bus.es_to_ms_bus   = es_b;
            bus.ws_allowin     = ws_a;
            #1;
            n_checks++;
            if (bus.ms_to_ws_valid !== m_valid)
                $display("FAIL rnd_valid[%0d]: got %b want %b", c, bus.ms_to_ws_valid, m_valid);
            else n_pass++;
            n_checks++;
            if (bus.ms_allowin !== (!m_valid || ws_a))
                $display("FAIL rnd_allowin[%0d]: got %b want %b", c, bus.ms_allowin, (!m_valid || ws_a));
            else n_pass++;
            if (m_valid) begin
                n_checks++;
                if (bus.ms_to_ws_bus !== model_ws(m_bus, m_word))
                    $display("FAIL rnd_bus[%0d]: got %h want %h", c, bus.ms_to_ws_bus, model_ws(m_bus, m_word));
                else n_pass++;
                n_checks++;
                if (bus.ms_to_ds_fwd_bus !== model_fwd(1'b1, m_bus, m_word))
                    $display("FAIL rnd_fwd[%0d]: got %h want %h", c, bus.ms_to_ds_fwd_bus, model_fwd(1'b1, m_bus, m_word));
                else n_pass++;
            end else begin
                n_checks++;
                if (bus.ms_to_ds_fwd_bus[37] !== 1'b0)
                    $display("FAIL rnd_fwd_we_idle[%0d]: got %b want 0", c, bus.ms_to_ds_fwd_bus[37]);
                else n_pass++;
            end
        end
        bus.es_to_ms_valid = 1'b0;
        bus.ws_allowin     = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_stall();
        bus.ws_allowin = 1'b1;
        issue(mk_inst(0, 1'b1, 1'b1, 4, 32'h10, 32'h900), 32'h7777_0000);
        bus.ws_allowin = 1'b0;
        tick();
        tick();
        n_checks++;
        if (bus.ms_to_ws_valid !== 1'b1) $display("FAIL rststall_pre_valid: got %b want 1", bus.ms_to_ws_valid);
        else n_pass++;
        reset = 1'b1;
        tick();
        n_checks++;
        if (bus.ms_to_ws_valid !== 1'b0) $display("FAIL rststall_valid: got %b want 0", bus.ms_to_ws_valid);
        else n_pass++;
        n_checks++;
        if (bus.ms_allowin !== 1'b1) $display("FAIL rststall_allowin: got %b want 1", bus.ms_allowin);
        else n_pass++;
        n_checks++;
        if (bus.ms_to_ds_fwd_bus[37] !== 1'b0) $display("FAIL rststall_fwd_we: got %b want 0", bus.ms_to_ds_fwd_bus[37]);
        else n_pass++;
        reset = 1'b0;
        tick();
        n_checks++;
        if (bus.ms_to_ws_valid !== 1'b0) $display("FAIL rststall_post_valid: got %b want 0", bus.ms_to_ws_valid);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_load_vectors();
        test_stall_hold();
        test_forward();
        test_back_to_back();
        test_random();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage in-order pipeline. Accepts instructions from EX over the es_to_ms valid/allowin handshake.
- Extracts and extends load data from the synchronous data SRAM.
- Drives ms_to_ws_bus and ms_to_ws_valid into the write-back stage, honouring ws_allowin backpressure.
- Exports a forwarding bus to ID for hazard detection and bypass.

Parameters:
- None. Bus widths are the mycpu.h macros: ES_TO_MS_BUS_WD=74, MS_TO_WS_BUS_WD=70, MS_TO_DS_FWD_WD=38.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- ws_allowin  in  1  WB can accept this cycle
- ms_allowin  out  1  MEM can accept from EX
- es_to_ms_valid  in  1  EX holds a valid instruction
- es_to_ms_bus  in  74  {ld_op[73:71], res_from_mem[70], gr_we[69], dest[68:64], alu_result[63:32], pc[31:0]}
- data_sram_rdata  in  32  SRAM read word; valid only in the first cycle after MEM latches a load
- ms_to_ws_valid  out  1  MEM holds a valid, ready instruction
- ms_to_ws_bus  out  70  {gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}
- ms_to_ds_fwd_bus  out  38  {fwd_we[37], fwd_dest[36:32], fwd_data[31:0]}

Behaviour:
- Handshake:
  - ms_ready_go = 1; ms_allowin = !ms_valid || (ms_ready_go && ws_allowin); ms_to_ws_valid = ms_valid && ms_ready_go.
  - ms_valid: reset -> 0; when ms_allowin, ms_valid <= es_to_ms_valid.
  - es_to_ms_bus_r loads only when es_to_ms_valid && ms_allowin. It holds while stalled.
- Load data capture:
  - SRAM rdata is valid only in the first cycle after capture.
  - first_cycle flag: set on every accepted instruction, cleared the next cycle. Reset clears it.
  - rdata_buf latches data_sram_rdata while first_cycle=1.
  - mem_word = first_cycle ? data_sram_rdata : rdata_buf. Stalled loads therefore keep correct data for any stall length.
- Load extraction, using addr = alu_result[1:0]:
  - ld_op 0 = LD_W: whole word.
  - ld_op 1 = LD_B: byte at addr, sign-extended.
  - ld_op 3 = LD_BU: byte at addr, zero-extended.
  - ld_op 2 = LD_H: halfword at addr[1] (0 -> [15:0], 1 -> [31:16]), sign-extended.
  - ld_op 4 = LD_HU: same halfword select, zero-extended.
  - ld_op 5..7: treated as LD_W.
  - Unaligned addresses are not checked here. The byte/half select uses the low address bits only.
- final_result = res_from_mem ? load_data : alu_result.
- ms_to_ws_bus = {gr_we, dest, final_result, pc}. It is driven from the registers regardless of ms_valid; WB qualifies it by valid.
- Forwarding: fwd_we = ms_valid && gr_we && (dest != 0); fwd_dest = dest; fwd_data = final_result.
- Reset values:
  - ms_valid=0, first_cycle=0, so ms_to_ws_valid=0 and fwd_we=0.
  - Bus payload registers are not reset.
- Boundary cases:
  - Simultaneous drain and fill: new bus captured and first_cycle re-set in the same edge.
  - es_to_ms_valid=0 while allowin: MEM goes empty.
  - Reset mid-stall: valid drops next edge; no output to WB.
  - Non-load with res_from_mem=0: the data path is ignored.

Decomposition:
- mycpu.h holds:
  - the three bus width macros;
  - ld_op encodings LD_W=0, LD_B=1, LD_H=2, LD_BU=3, LD_HU=4.
- One natural combinational sub-module, load_align: (mem_word, addr[1:0], ld_op) -> load_data[31:0]. Unit-testable in isolation.

Test Plan:
- LD_B, alu_result=0x1003, rdata=0x80FF_1234, ws_allowin=1 -> next cycle final_result=0xFFFF_FF80, ms_to_ws_valid=1.
- LD_HU, addr[1:0]=2, rdata=0xBEEF_0001 -> final_result=0x0000_BEEF. LD_H with the same inputs -> 0xFFFF_BEEF.
- LD_W accepted, ws_allowin=0 for 3 cycles, rdata driven to 0xDEAD_DEAD after the first cycle (original 0x1234_5678) -> ms_allowin=0 during the stall; final_result stays 0x1234_5678; on release, exactly one ms_to_ws_valid pulse.
- ALU op with res_from_mem=0, alu_result=0xCAFE_0000, dest=5, gr_we=1 -> fwd_bus={1,5,0xCAFE_0000}. Same op with dest=0 -> fwd_we=0.
- Back-to-back valid instructions with ws_allowin=1 -> one output per cycle, PCs in order, no bubbles.
- Reset asserted mid-stall with ms_valid=1 -> next cycle ms_to_ws_valid=0, ms_allowin=1, fwd_we=0.
